// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and dimension clamp for the matrix generator/reader pair.
package matrix_pkg;

  localparam int unsigned MAX_DIM  = 5;
  localparam int unsigned NUM_ELEM = MAX_DIM * MAX_DIM;
  localparam int unsigned ELEM_W   = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StDone = 2'd2
  } state_e;

  // Zero is treated as one so every start yields at least one element.
  function automatic logic [2:0] clamp_dim(input logic [2:0] dim, input logic [2:0] max_dim);
    if (dim == 3'd0) begin
      return 3'd1;
    end
    if (dim > max_dim) begin
      return max_dim;
    end
    return dim;
  endfunction

endpackage

// File: rtl/matrix_stream_reader_if.sv
// Element stream from the matrix reader to the downstream printer: valid/ready plus tags.
interface matrix_stream_reader_if #(
  parameter int unsigned WIDTH = 8
);

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_row;
  logic [2:0]       out_col;
  logic             out_eol;
  logic             out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_row,
    output out_col,
    output out_eol,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_row,
    input  out_col,
    input  out_eol,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/matrix_stream_reader.sv
// Snapshots a flat matrix bus on start and streams the valid row x col elements in
// row-major order, tagging row ends and the final element.
module matrix_stream_reader #(
  parameter int unsigned WIDTH   = matrix_pkg::ELEM_W,
  parameter int unsigned MAX_DIM = matrix_pkg::MAX_DIM
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [2:0]                       row,
  input  logic [2:0]                       col,
  input  logic [MAX_DIM*MAX_DIM*WIDTH-1:0] matrix_in,
  matrix_stream_reader_if.master           stream,
  output logic                             busy,
  output logic                             done
);

  import matrix_pkg::*;

  localparam int unsigned BusW = MAX_DIM * MAX_DIM * WIDTH;
  localparam logic [2:0]  DimMax = 3'(MAX_DIM);

  state_e          state_q, state_d;
  logic [2:0]      nrow_q, nrow_d;
  logic [2:0]      ncol_q, ncol_d;
  logic [2:0]      cur_r_q, cur_r_d;
  logic [2:0]      cur_c_q, cur_c_d;
  logic [BusW-1:0] snap_q, snap_d;

  logic            sending;
  logic            last_col;
  logic            last_row;
  int unsigned     idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      nrow_q  <= '0;
      ncol_q  <= '0;
      cur_r_q <= '0;
      cur_c_q <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      nrow_q  <= nrow_d;
      ncol_q  <= ncol_d;
      cur_r_q <= cur_r_d;
      cur_c_q <= cur_c_d;
      snap_q  <= snap_d;
    end
  end

  assign sending  = (state_q == StSend);
  assign last_col = (cur_c_q == ncol_q - 3'd1);
  assign last_row = (cur_r_q == nrow_q - 3'd1);

  always_comb begin
    state_d = state_q;
    nrow_d  = nrow_q;
    ncol_d  = ncol_q;
    cur_r_d = cur_r_q;
    cur_c_d = cur_c_q;
    snap_d  = snap_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          snap_d  = matrix_in;
          nrow_d  = clamp_dim(row, DimMax);
          ncol_d  = clamp_dim(col, DimMax);
          cur_r_d = '0;
          cur_c_d = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (stream.out_ready) begin
          if (last_col) begin
            cur_c_d = '0;
            if (last_row) begin
              state_d = StDone;
            end else begin
              cur_r_d = cur_r_q + 3'd1;
            end
          end else begin
            cur_c_d = cur_c_q + 3'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Every stream output is forced to zero outside SEND so idle cycles look clean.
  always_comb begin
    idx              = 32'(cur_r_q) * MAX_DIM + 32'(cur_c_q);
    stream.out_valid = sending;
    stream.out_data  = '0;
    stream.out_row   = '0;
    stream.out_col   = '0;
    stream.out_eol   = 1'b0;
    stream.out_last  = 1'b0;
    if (sending) begin
      stream.out_data = snap_q[idx*WIDTH +: WIDTH];
      stream.out_row  = cur_r_q;
      stream.out_col  = cur_c_q;
      stream.out_eol  = last_col;
      stream.out_last = last_col && last_row;
    end
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

endmodule

// File: tb/tb_matrix_stream_reader.sv
// Self-checking bench for matrix_stream_reader against a row-major list model.
module tb_matrix_stream_reader;

  localparam int W = 8;
  localparam int D = 5;
  localparam int N = D * D;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       row;
  logic [2:0]       col;
  logic [N*W-1:0]   matrix_in;
  logic             busy;
  logic             done;

  matrix_stream_reader_if #(.WIDTH(W)) sif ();

  matrix_stream_reader #(
    .WIDTH  (W),
    .MAX_DIM(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .row      (row),
    .col      (col),
    .matrix_in(matrix_in),
    .stream   (sif.master),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mat [N];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int done_cnt, unstable, first_cyc, last_cyc, done_cyc, busy_after;

  function automatic logic [15:0] pack(input logic [7:0] d, input int r, input int c,
                                       input bit eol, input bit last);
    return {d, 3'(r), 3'(c), eol, last};
  endfunction

  task automatic load_matrix(input bit rnd);
    for (int k = 0; k < N; k++) begin
      mat[k] = rnd ? 8'($urandom) : 8'(k + 1);
      matrix_in[k*W +: W] = mat[k];
    end
  endtask

  // Expected stream: every (r, c) inside the clamped dimensions, row-major.
  task automatic build_expected(input int r_in, input int c_in);
    int nr, nc;
    nr = (r_in == 0) ? 1 : ((r_in > D) ? D : r_in);
    nc = (c_in == 0) ? 1 : ((c_in > D) ? D : c_in);
    exp_q.delete();
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++)
        exp_q.push_back(pack(mat[r*D+c], r, c, c == nc - 1, (r == nr - 1) && (c == nc - 1)));
  endtask

  task automatic apply_start(input int r, input int c);
    start = 1'b1;
    row   = 3'(r);
    col   = 3'(c);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Records accepted elements and timing; mode 0: always ready, 1: 1,0,0 pattern, 2: random.
  task automatic collect(input int mode, input bit poke);
    logic [15:0] held;
    bit holding;
    bit fin;
    holding = 0;
    fin = 0;
    held = '0;
    got_q.delete();
    done_cnt = 0; unstable = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; busy_after = -1;
    for (int n = 0; n < 400 && !fin; n++) begin
      bit rdy;
      logic [15:0] cur;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (n % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      sif.out_ready = rdy;
      if (poke) begin
        start = (n == 2);
        if (n == 2) matrix_in = '1;
      end
      cur = pack(sif.out_data, int'(sif.out_row), int'(sif.out_col), sif.out_eol, sif.out_last);
      if (holding && (!sif.out_valid || cur !== held)) unstable++;
      holding = 0;
      if (sif.out_valid) begin
        if (first_cyc < 0) first_cyc = n;
        if (rdy) begin
          got_q.push_back(cur);
          last_cyc = n;
        end else begin
          holding = 1;
          held = cur;
        end
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (done_cyc >= 0 && n == done_cyc + 1) begin
        busy_after = int'(busy);
        fin = 1;
      end
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({sif.out_valid, sif.out_data, sif.out_row, sif.out_col, sif.out_eol, sif.out_last,
         busy, done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b data=%h row=%0d col=%0d eol=%b last=%b busy=%b done=%b, want all 0",
               sif.out_valid, sif.out_data, sif.out_row, sif.out_col, sif.out_eol, sif.out_last,
               busy, done);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || sif.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b valid=%b, want 0 0", busy, sif.out_valid);
    end
  endtask

  task automatic test_basic_2x3;
    load_matrix(0);
    build_expected(2, 3);
    apply_start(2, 3);
    collect(0, 0);
    total++;
    if (got_q.size() != 6) begin
      bad++;
      $display("FAIL basic_count: got %0d elements, want 6", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL basic_elem%0d: got %h, want %h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (first_cyc != 0 || done_cyc != last_cyc + 1 || busy_after != 0 || done_cnt != 1) begin
      bad++;
      $display("FAIL basic_timing: got first=%0d last=%0d done=%0d busy_after=%0d dones=%0d, want 0 5 6 0 1",
               first_cyc, last_cyc, done_cyc, busy_after, done_cnt);
    end
  endtask

  task automatic test_backpressure;
    load_matrix(0);
    build_expected(3, 3);
    apply_start(3, 3);
    collect(1, 0);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL bp_count: got %0d elements, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL bp_elem%0d: got %h, want %h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (unstable != 0 || done_cnt != 1) begin
      bad++;
      $display("FAIL bp_stall_stable: got unstable=%0d dones=%0d, want 0 1", unstable, done_cnt);
    end
  endtask

  task automatic test_clamp;
    int rs[2] = '{0, 7};
    int cs[2] = '{7, 0};
    for (int t = 0; t < 2; t++) begin
      load_matrix(0);
      build_expected(rs[t], cs[t]);
      apply_start(rs[t], cs[t]);
      collect(0, 0);
      total++;
      if (got_q.size() != 5) begin
        bad++;
        $display("FAIL clamp%0d_count: got %0d elements, want 5", t, got_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL clamp%0d_elem%0d: got %h, want %h", t, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_snapshot;
    int errs;
    load_matrix(1);
    build_expected(5, 5);
    apply_start(5, 5);
    collect(2, 1);
    errs = 0;
    total++;
    if (got_q.size() != 25) begin
      bad++;
      $display("FAIL snap_count: got %0d elements, want 25", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL snap_values: got %0d wrong elements, want 0", errs);
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    total++;
    if (done_cnt != 1 || busy !== 1'b0 || sif.out_valid !== 1'b0 || unstable != 0) begin
      bad++;
      $display("FAIL snap_no_restart: got dones=%0d busy=%b valid=%b unstable=%0d, want 1 0 0 0",
               done_cnt, busy, sif.out_valid, unstable);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    load_matrix(0);
    apply_start(5, 5);
    sif.out_ready = 1'b1;
    seen = 0;
    for (int n = 0; n < 4; n++) begin
      if (sif.out_valid) seen++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (seen != 4 || sif.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got transfers=%0d valid=%b busy=%b done=%b, want 4 0 0 0",
               seen, sif.out_valid, busy, done);
    end
    apply_start(1, 1);
    collect(0, 0);
    total++;
    if (got_q.size() != 1 || got_q[0] !== pack(8'd1, 0, 0, 1'b1, 1'b1) || done_cnt != 1) begin
      bad++;
      $display("FAIL one_by_one: got n=%0d elem=%h dones=%0d, want 1 %h 1", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 16'h0, done_cnt, pack(8'd1, 0, 0, 1'b1, 1'b1));
    end
  endtask

  task automatic test_back_to_back;
    for (int t = 0; t < 3; t++) begin
      int r, c, errs;
      r = int'($urandom_range(0, 7));
      c = int'($urandom_range(0, 7));
      load_matrix(1);
      build_expected(r, c);
      // Previous collect returns on the IDLE cycle right after done.
      apply_start(r, c);
      collect(0, 0);
      errs = 0;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        if (got_q[i] !== exp_q[i]) errs++;
      total++;
      if (got_q.size() != exp_q.size() || errs != 0 || first_cyc != 0 || busy_after != 0) begin
        bad++;
        $display("FAIL b2b%0d (%0dx%0d): got n=%0d errs=%0d first=%0d busy_after=%0d, want n=%0d 0 0 0",
                 t, r, c, got_q.size(), errs, first_cyc, busy_after, exp_q.size());
      end
    end
  endtask

  task automatic test_random;
    for (int t = 0; t < 8; t++) begin
      int r, c, errs;
      r = int'($urandom_range(0, 7));
      c = int'($urandom_range(0, 7));
      load_matrix(1);
      build_expected(r, c);
      apply_start(r, c);
      collect(2, 0);
      errs = 0;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        if (got_q[i] !== exp_q[i]) errs++;
      total++;
      if (got_q.size() != exp_q.size() || errs != 0 || unstable != 0 || done_cnt != 1) begin
        bad++;
        $display("FAIL rand%0d (%0dx%0d): got n=%0d errs=%0d unstable=%0d dones=%0d, want n=%0d 0 0 1",
                 t, r, c, got_q.size(), errs, unstable, done_cnt, exp_q.size());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    row = '0;
    col = '0;
    matrix_in = '0;
    sif.out_ready = 1'b0;
    test_reset();
    test_basic_2x3();
    test_backpressure();
    test_clamp();
    test_snapshot();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_stream_reader.md
Name: matrix_stream_reader

Overview:
- Consumer-side counterpart of the matrix generator: snapshots a flat 5×5 matrix bus and streams only the valid row×col elements, one per handshake, in row-major order.
- Feeds the UART/display formatter that prints matrices.
- Skips padding positions and marks row ends and the last element, so the downstream printer needs no knowledge of matrix dimensions.

Parameters:
- WIDTH, 8, element bit width.
- MAX_DIM, 5, maximum rows/cols; flat bus holds MAX_DIM*MAX_DIM elements.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new read-out; sampled only in IDLE.
- row  input  3  matrix rows, clamped to 1..MAX_DIM at start.
- col  input  3  matrix cols, clamped to 1..MAX_DIM at start.
- matrix_in  input  MAX_DIM*MAX_DIM*WIDTH  flat matrix; element k = r*MAX_DIM+c at bits [k*WIDTH +: WIDTH].
- out_ready  input  1  downstream accepts the current element.
- out_valid  output  1  out_data, out_row, out_col, out_eol and out_last are valid.
- out_data  output  WIDTH  element value.
- out_row  output  3  row index 0..MAX_DIM-1 of out_data.
- out_col  output  3  column index 0..MAX_DIM-1 of out_data.
- out_eol  output  1  element is the last of its row (col == clamped_col-1).
- out_last  output  1  element is the last of the matrix.
- busy  output  1  high in SEND and DONE.
- done  output  1  one-cycle pulse after the last element is accepted.

Behaviour:
- Reset (rst=1 at a clock edge, any state, including mid-stream):
  - State → IDLE.
  - All outputs 0.
  - Row/col counters 0.
  - Snapshot registers 0.
  - Any in-flight stream is abandoned with no done pulse.
- States: IDLE, SEND, DONE.
- IDLE:
  - out_valid=0, busy=0.
  - On start=1, in the same edge:
    - Register the snapshot of matrix_in.
    - Register clamped row/col: 0→1; >MAX_DIM→MAX_DIM.
    - cur_r=0, cur_c=0.
    - Go to SEND.
- SEND:
  - out_valid=1 from the first cycle after start (latency 1).
  - out_data = snap[cur_r*MAX_DIM+cur_c], driven from registers.
  - Transfer occurs when out_valid && out_ready.
  - On a transfer:
    - cur_c==ncol-1 and cur_r==nrow-1 → DONE.
    - Otherwise cur_c==ncol-1 → cur_c=0, cur_r+1.
    - Otherwise cur_c+1.
  - Without out_ready, all out_* hold stable; no change while stalled.
  - start is ignored while in SEND.
  - matrix_in changes after start do not affect the stream (snapshot only).
- DONE:
  - out_valid=0, done=1 for exactly this one cycle.
  - Next cycle → IDLE.
  - start during DONE is ignored; it must be presented again in IDLE.
- Element count: exactly nrow*ncol transfers per start (1 minimum, 25 maximum).
- Minimum interval between done and the next first element: 2 cycles.
- Index arithmetic: k = cur_r*MAX_DIM + cur_c fits 5 bits, maximum 24. No wrap is possible because the counters never exceed the clamped dimensions.
- 1×1 matrix: a single element with out_eol=1 and out_last=1.
- start and rst both high: rst wins.

Decomposition:
- Shared package matrix_pkg holds:
  - constants MAX_DIM=5, NUM_ELEM=25, ELEM_W=8;
  - state encoding localparams for IDLE/SEND/DONE;
  - a dimension-clamp function shared with the generator.
- Sub-module: none required. The snapshot register file plus 25:1 mux is simple enough to stay inline.
- Optional helper matrix_dim_clamp (combinational) if the package function is not usable.

Test Plan:
1. 2×3 matrix, elements k=0..24 hold value k+1, start pulse, out_ready held at 1.
   - Stream, one per cycle starting 1 cycle after start: 1,2,3,6,7,8.
   - out_eol on 3 and 8; out_last on 8.
   - done 1 cycle after the last transfer; busy low the cycle after that.
2. Backpressure on a 3×3 matrix: out_ready toggles 1,0,0,1,…
   - Each element is held stable during stalls.
   - Sequence is 1,2,3,6,7,8,11,12,13 with no duplicates or drops.
3. Clamping:
   - row=0, col=7 → 1×5 stream of 1,2,3,4,5; out_last on 5.
   - row=7, col=0 → 5×1 stream of 1,6,11,16,21.
4. Snapshot and start-while-busy on a 5×5 matrix:
   - Change matrix_in to all 8'hFF and pulse start during SEND.
   - Original 25 values stream in full, then a single done; no restart.
5. Reset mid-stream: assert rst after the 4th transfer of a 5×5 matrix.
   - Next cycle out_valid=0, busy=0, done=0.
   - A subsequent start on a 1×1 matrix yields a single element of value 1 with eol=1 and last=1.
6. Back-to-back runs: start asserted on the IDLE cycle right after done.
   - Second stream begins 1 cycle later, with new dimensions latched correctly.
